stepper_cmd_queue: RTL and testbench

Memory-mapped stepper-motor command block on the processor's data-memory bus, directly downstream of the processor store port. It decodes `sw` stores to a small address window, queues move commands in a FIFO, and replays each command as a precisely timed step/dir pulse train for the motor driver. Status is exported so the processor or the top level can poll for completion.

---
 rtl/stepper_cmd_queue.sv | 209 ++++++++++++++++++++
 tb/tb_stepper_cmd_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_cmd_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stepper_cmd_queue : store-mapped move-command FIFO + step/dir pulser |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module stepper_cmd_queue #(
  parameter logic [11:0] BASE_ADDR      = 12'hF00,
  parameter int          FIFO_DEPTH     = 4,
  parameter int          PULSE_WIDTH    = 2,
  parameter logic [15:0] DEFAULT_PERIOD = 16'd1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wren,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  output logic        step,
  output logic        dir,
  output logic        busy,
  output logic        done,
  output logic [31:0] status
);

  localparam int          AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW         = AW + 1;
  localparam logic [16:0] PW17       = 17'(PULSE_WIDTH);
  localparam logic [16:0] PW_M1      = 17'(PULSE_WIDTH - 1);
  localparam logic [16:0] MIN_P      = 17'(2 * PULSE_WIDTH);
  localparam logic [11:0] ADDR_CMD   = BASE_ADDR;
  localparam logic [11:0] ADDR_PER   = BASE_ADDR + 12'd1;
  localparam logic [11:0] ADDR_CTRL  = BASE_ADDR + 12'd2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_LOW  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [16:0]   mem_q [FIFO_DEPTH];
  logic [16:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   period_q, period_d;
  logic [16:0]   cmd_q, cmd_d;
  logic [15:0]   remaining_q, remaining_d;
  logic [16:0]   p_q, p_d;
  logic [16:0]   cnt_q, cnt_d;
  logic          fin_q, fin_d;
  logic          step_q, step_d, dir_q, dir_d, done_q, done_d, busy_q, busy_d;
  logic [31:0]   status_q, status_d;

  logic          sel_cmd, sel_per, sel_ctrl, abort, clr_ovf;
  logic          full, empty, push, pop;
  logic [16:0]   p_eff;
  logic          unused_bits;

  assign unused_bits = ^{address_dmem[31:12], data[30:16]};

  // Bus decode and FIFO / register bookkeeping
  always_comb begin
    sel_cmd  = wren && (address_dmem[11:0] == ADDR_CMD);
    sel_per  = wren && (address_dmem[11:0] == ADDR_PER);
    sel_ctrl = wren && (address_dmem[11:0] == ADDR_CTRL);
    abort    = sel_ctrl && data[0];
    clr_ovf  = sel_ctrl && data[1];
    full     = (count_q == CW'(FIFO_DEPTH));
    empty    = (count_q == '0);
    push     = sel_cmd && !full && !abort;
    pop      = (state_q == S_IDLE) && !empty && !abort;
    p_eff    = ({1'b0, period_q} > MIN_P) ? {1'b0, period_q} : MIN_P;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {data[31], data[15:0]};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    overflow_d = overflow_q;
    if (clr_ovf) overflow_d = 1'b0;
    if (sel_cmd && full && !abort) overflow_d = 1'b1;
    period_d = sel_per ? data[15:0] : period_q;
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    remaining_d = remaining_q;
    p_d         = p_q;
    cmd_d       = cmd_q;
    fin_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          cmd_d   = mem_q[rd_ptr_q];
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        remaining_d = cmd_q[15:0];
        p_d         = p_eff;
        cnt_d       = '0;
        state_d     = (cmd_q[15:0] == 16'd0) ? S_IDLE : S_HIGH;
      end
      S_HIGH: begin
        if (cnt_q == PW_M1) begin
          cnt_d   = '0;
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q + 17'd1;
        end
      end
      default: begin
        if (cnt_q == p_q - PW17 - 17'd1) begin
          cnt_d       = '0;
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            state_d = S_IDLE;
            fin_d   = 1'b1;
          end else begin
            state_d = S_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 17'd1;
        end
      end
    endcase
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      fin_d   = 1'b0;
    end
  end

  // Outputs trail the state by one edge; done for a real move therefore waits
  // for fin_q so it lands after the final low interval has elapsed on the pin.
  always_comb begin
    step_d   = (state_q == S_HIGH) && !abort;
    dir_d    = ((state_q == S_LOAD) && !abort) ? cmd_q[16] : dir_q;
    done_d   = !abort && (fin_q || ((state_q == S_LOAD) && (cmd_q[15:0] == 16'd0)));
    busy_d   = (state_q != S_IDLE) || !empty;
    status_d = {16'b0, 8'(count_q), 4'b0, overflow_q, full, empty, busy_d};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      period_q    <= DEFAULT_PERIOD;
      cmd_q       <= '0;
      remaining_q <= '0;
      p_q         <= MIN_P;
      cnt_q       <= '0;
      fin_q       <= 1'b0;
      step_q      <= 1'b0;
      dir_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      status_q    <= 32'h0000_0002;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      period_q    <= period_d;
      cmd_q       <= cmd_d;
      remaining_q <= remaining_d;
      p_q         <= p_d;
      cnt_q       <= cnt_d;
      fin_q       <= fin_d;
      step_q      <= step_d;
      dir_q       <= dir_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      status_q    <= status_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign step   = step_q;
  assign dir    = dir_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign status = status_q;

endmodule
`default_nettype wire

// File: tb/tb_stepper_cmd_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_stepper_cmd_queue : scoreboard bench for stepper_cmd_queue        |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_stepper_cmd_queue;

  localparam logic [11:0] A_CMD  = 12'hF00;
  localparam logic [11:0] A_PER  = 12'hF01;
  localparam logic [11:0] A_CTRL = 12'hF02;
  localparam int K_STEP = 0;
  localparam int K_DONE = 1;

  logic        clk;
  logic        reset;
  logic        wren;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        step, dir, busy, done;
  logic [31:0] status;

  typedef struct {
    int   kind;
    int   cyc;
    logic dir;
    int   width;
  } ev_t;

  ev_t  exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic step_prev = 1'b0;
  int   hi_cnt = 0;
  int   exp_w = 0;

  stepper_cmd_queue #(
    .BASE_ADDR      (12'hF00),
    .FIFO_DEPTH     (4),
    .PULSE_WIDTH    (2),
    .DEFAULT_PERIOD (16'd1000)
  ) dut (
    .clock        (clk),
    .reset        (reset),
    .wren         (wren),
    .address_dmem (address_dmem),
    .data         (data),
    .step         (step),
    .dir          (dir),
    .busy         (busy),
    .done         (done),
    .status       (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_step(input int c, input logic d, input int w);
    exp_q.push_back('{K_STEP, c, d, w});
  endtask

  task automatic exp_done(input int c);
    exp_q.push_back('{K_DONE, c, 1'b0, 0});
  endtask

  task automatic match_event(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
      return;
    end
    e = exp_q.pop_front();
    if (kind == K_STEP) exp_w = e.width;
    if (e.kind != kind || e.cyc != cyc || (kind == K_STEP && e.dir !== dir)) begin
      errors++;
      $display("FAIL event: got kind %0d cyc %0d dir %b, expected kind %0d cyc %0d dir %b",
               kind, cyc, dir, e.kind, e.cyc, e.dir);
    end
  endtask

  // Monitor: step rises and done pulses are matched against the scoreboard
  always @(negedge clk) begin
    if (step === 1'b1 && step_prev !== 1'b1) begin
      match_event(K_STEP);
      hi_cnt = 1;
    end else if (step === 1'b1) begin
      hi_cnt++;
    end else if (step_prev === 1'b1) begin
      checks++;
      if (hi_cnt != exp_w) begin
        errors++;
        $display("FAIL step_width: got %0d expected %0d (cycle %0d)", hi_cnt, exp_w, cyc);
      end
    end
    if (done === 1'b1) match_event(K_DONE);
    step_prev = step;
  end

  // Called right after a falling edge; the write lands on the next rising edge.
  task automatic bus_wr(input logic [11:0] a, input logic [31:0] d, output int e0);
    wren         = 1'b1;
    address_dmem = {20'h0, a};
    data         = d;
    e0           = cyc + 1;
    @(negedge clk);
    wren = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d events still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, w;
    reset = 1'b1; wren = 1'b0; address_dmem = '0; data = '0;
    repeat (3) @(negedge clk);
    chk("reset_step",   {31'b0, step}, 32'd0);
    chk("reset_dir",    {31'b0, dir},  32'd0);
    chk("reset_busy",   {31'b0, busy}, 32'd0);
    chk("reset_done",   {31'b0, done}, 32'd0);
    chk("reset_status", status,        32'h0000_0002);
    reset = 1'b0;
    @(negedge clk);

    // Three steps at P=10
    bus_wr(A_PER, 32'd10, w);
    bus_wr(A_CMD, 32'h0000_0003, e0);
    exp_step(e0 + 3, 1'b0, 2); exp_step(e0 + 13, 1'b0, 2); exp_step(e0 + 23, 1'b0, 2);
    exp_done(e0 + 33);
    drain(60, "t1");
    @(negedge clk);
    chk("t1_busy_after", {31'b0, busy}, 32'd0);
    chk("t1_status_after", status, 32'h0000_0002);

    // Period below 2*PULSE_WIDTH is clamped to 4
    bus_wr(A_PER, 32'd1, w);
    bus_wr(A_CMD, 32'h8000_0001, e0);
    exp_step(e0 + 3, 1'b1, 2); exp_done(e0 + 7);
    drain(30, "t2");

    // Zero-step command: only a done pulse, dir reloaded
    bus_wr(A_CMD, 32'h0000_0000, e0);
    exp_done(e0 + 2);
    drain(20, "t3");
    @(negedge clk);
    chk("t3_dir", {31'b0, dir}, 32'd0);
    chk("t3_status", status, 32'h0000_0002);

    // Period write mid-command only affects the next command
    bus_wr(A_PER, 32'd10, w);
    bus_wr(A_CMD, 32'h0000_0002, e0);
    bus_wr(A_CMD, 32'h8000_0002, w);
    exp_step(e0 + 3, 1'b0, 2); exp_step(e0 + 13, 1'b0, 2); exp_done(e0 + 23);
    exp_step(e0 + 25, 1'b1, 2); exp_step(e0 + 45, 1'b1, 2); exp_done(e0 + 65);
    wait_until(e0 + 5);
    bus_wr(A_PER, 32'd20, w);
    drain(100, "t4");

    // Fill the FIFO behind a running move, overflow, clear, abort
    bus_wr(A_PER, 32'd10, w);
    bus_wr(A_CMD, 32'd1000, e0);
    exp_step(e0 + 3, 1'b0, 2);
    wait_until(e0 + 3);
    for (int i = 0; i < 5; i++) bus_wr(A_CMD, 32'd1000, w);
    chk("t5_status_full", status, 32'h0000_0405);
    @(negedge clk);
    chk("t5_status_ovf", status, 32'h0000_040D);
    bus_wr(A_CTRL, 32'd2, w);
    @(negedge clk);
    chk("t5_status_clr", status, 32'h0000_0405);
    bus_wr(A_CTRL, 32'd1, w);
    chk("t5_step_abort", {31'b0, step}, 32'd0);
    @(negedge clk);
    chk("t5_status_abort", status, 32'h0000_0002);
    chk("t5_busy_abort", {31'b0, busy}, 32'd0);
    repeat (30) @(negedge clk);
    chk("t5_no_events", exp_q.size(), 32'd0);

    // Abort during HIGH of the second of three queued commands
    bus_wr(A_CMD, 32'h0000_0001, e0);
    bus_wr(A_CMD, 32'h8000_0003, w);
    bus_wr(A_CMD, 32'h0000_0001, w);
    exp_step(e0 + 3, 1'b0, 2); exp_done(e0 + 13); exp_step(e0 + 15, 1'b1, 1);
    wait_until(e0 + 15);
    chk("t6_status_pre", status, 32'h0000_0101);
    bus_wr(A_CTRL, 32'd1, w);
    chk("t6_step_abort", {31'b0, step}, 32'd0);
    @(negedge clk);
    chk("t6_status_abort", status, 32'h0000_0002);
    chk("t6_busy_abort", {31'b0, busy}, 32'd0);
    chk("t6_dir_hold", {31'b0, dir}, 32'd1);
    repeat (40) @(negedge clk);
    chk("t6_no_events", exp_q.size(), 32'd0);

    // Reset in the middle of a move
    bus_wr(A_CMD, 32'h8000_0005, e0);
    exp_step(e0 + 3, 1'b1, 1);
    wait_until(e0 + 3);
    reset = 1'b1;
    @(negedge clk);
    chk("t7_step", {31'b0, step}, 32'd0);
    chk("t7_dir", {31'b0, dir}, 32'd0);
    chk("t7_status", status, 32'h0000_0002);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("t7_no_events", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
